move_intent: RTL
================

# move_intent

Turn-buffering front end for the PacMan movement stage. Converts the raw per-frame USB keycode into a sticky, wall-aware movement key, so PacMan keeps travelling after the key is released. A turn pressed slightly early is held and taken on the first frame that direction opens. Sits between the keyboard keycode register and the movement module, and uses the same mapL/mapR/mapB/mapT wall flags.

## Interface
- PRE_TURN_FRAMES, 16: frames a buffered turn stays pending after the key is last seen; legal range 1..255.
- frame_clk  input  1  frame clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- restart  input  1  synchronous game restart; clears all state.
- lifeDown  input  1  synchronous life-lost pulse; clears all state.
- keycode  input  8  raw keycode: 8'h04 left, 8'h07 right, 8'h16 down, 8'h1A up; anything else means no arrow.
- mapL, mapR, mapB, mapT  input  5 each  wall flags around PacMan; zero means open.
- move_key  output  8  sticky keycode driven to the movement stage; 8'h00 when stopped.
- cur_dir  output  3  committed direction: 0 NONE, 1 LEFT, 2 RIGHT, 3 DOWN, 4 UP.
- pend_dir  output  3  buffered turn direction; NONE when none is pending.
- pend_valid  output  1  a buffered turn is pending.

## Operation
- State registers:
  - cur_dir.
  - pend_dir.
  - pend_cnt: width $clog2(PRE_TURN_FRAMES+1), unsigned, never wraps below 0.
- Input decode: k = dir(keycode). Non-arrow keycodes decode to NONE.
- open(d): the map flag for d equals 0. open(NONE) is false.
- Per-frame update, first matching rule wins:
  1. restart or lifeDown: cur_dir, pend_dir, pend_cnt and move_key all go to zero or NONE.
  2. Request selection:
     - k != NONE and k != cur_dir: request r = k, pend_cnt reloads to PRE_TURN_FRAMES.
     - k == cur_dir (not NONE): any pending turn is cancelled, r = NONE.
     - k == NONE: r = pend_dir. pend_cnt decrements; reaching 0 clears pend_dir.
  3. Acceptance: r != NONE and open(r). Then cur_dir becomes r and pend_dir/pend_cnt are cleared. Reversals follow the same rule; there is no special case for them.
  4. Otherwise, when r != NONE, pend_dir becomes r. Also, when cur_dir != NONE and !open(cur_dir), cur_dir becomes NONE (stop at wall); pend_dir is retained.
- move_key is registered: dir-to-key of the next cur_dir. It is never a non-arrow value other than 8'h00.
- pend_valid = (pend_dir != NONE).
- Holding a blocked direction reloads pend_cnt every frame, so the pending turn never expires while the key is held.

## Timing
- Reset values: move_key 8'h00, cur_dir 0, pend_dir 0, pend_valid 0, pend_cnt 0.
- Latency: a keycode or map flag sampled at edge n is reflected on move_key after edge n. The movement stage acts on it at edge n+1.
- A pending turn expires exactly PRE_TURN_FRAMES frames after the last frame its key was present, unless accepted earlier.
- Simultaneous events:
  - restart/lifeDown override any key.
  - A new key overwrites the pending turn and restarts the timer.
  - Acceptance in the same frame as expiry wins.
- Reset asserted mid-frame clears all state immediately. The first post-reset edge behaves as from idle.

## Structure
- Shared pacman_pkg holds:
  - dir_t enum (NONE, LEFT, RIGHT, DOWN, UP).
  - KEY_LEFT/RIGHT/DOWN/UP constants.
  - key_to_dir and dir_to_key functions, which the movement stage and ghost logic reuse.
- The block is a single module with no sub-module. The counter and decode are small enough to stay inline.

## Test plan
- Idle, tap left: keycode 8'h04 for 1 frame with mapL=0, then 8'h00 for 20 frames -> move_key 8'h04 from frame 1 onward, held with no key.
- Moving left into a wall: mapL goes to 5'h1F at frame 10 -> cur_dir NONE and move_key 8'h00 after that edge.
- Early turn: moving right with mapT=1, tap up for 1 frame at frame 5, mapT=0 at frame 12 -> move_key becomes 8'h1A after edge 12; pend_valid high during frames 5-11.
- Expiry: PRE_TURN_FRAMES=4, tap down with mapB=1, hold mapB=1 -> pend_valid drops 4 frames after the tap; later mapB=0 causes no turn.
- Cancel and reset: pending up, then press the current direction -> pend_valid 0. Pending turn, then lifeDown pulse -> all outputs zero next edge. Async Reset mid-frame -> outputs zero without a clock edge.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared PacMan movement types: direction encoding and keycode <-> direction helpers.
// Reused by the movement stage and the ghost logic.
package pacman_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    DOWN  = 3'd3,
    UP    = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  // Any keycode that is not an arrow decodes to NONE.
  function automatic dir_t key_to_dir(input logic [7:0] key);
    dir_t d;
    case (key)
      KEY_LEFT:  d = LEFT;
      KEY_RIGHT: d = RIGHT;
      KEY_DOWN:  d = DOWN;
      KEY_UP:    d = UP;
      default:   d = NONE;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] dir_to_key(input dir_t d);
    logic [7:0] key;
    case (d)
      LEFT:    key = KEY_LEFT;
      RIGHT:   key = KEY_RIGHT;
      DOWN:    key = KEY_DOWN;
      UP:      key = KEY_UP;
      default: key = KEY_NONE;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/move_intent.sv
// Turn-buffering front end: turns the raw per-frame keycode into a sticky, wall-aware
// movement key, holding an early turn until its direction opens or its timer runs out.
module move_intent
  import pacman_pkg::*;
#(
  parameter int PRE_TURN_FRAMES = 16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       restart,
  input  logic       lifeDown,
  input  logic [7:0] keycode,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] move_key,
  output logic [2:0] cur_dir,
  output logic [2:0] pend_dir,
  output logic       pend_valid
);

  localparam int CW = $clog2(PRE_TURN_FRAMES + 1);
  localparam logic [CW-1:0] PRE_CNT = CW'(PRE_TURN_FRAMES);

  dir_t          cur_q, cur_d;
  dir_t          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
  logic [7:0]    key_q, key_d;
  dir_t          k, r;
  logic          expire;

  function automatic logic dir_open(input dir_t d);
    logic o;
    case (d)
      LEFT:    o = (mapL == 5'd0);
      RIGHT:   o = (mapR == 5'd0);
      DOWN:    o = (mapB == 5'd0);
      UP:      o = (mapT == 5'd0);
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  always_comb begin
    k       = key_to_dir(keycode);
    cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    cur_d   = cur_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    r       = NONE;
    expire  = 1'b0;

    if (restart || lifeDown) begin
      cur_d  = NONE;
      pend_d = NONE;
      cnt_d  = '0;
    end else begin
      if (k != NONE && k != cur_q) begin
        r     = k;
        cnt_d = PRE_CNT;
      end else if (k != NONE) begin
        // Pressing the direction already travelled cancels any buffered turn.
        r      = NONE;
        pend_d = NONE;
        cnt_d  = '0;
      end else begin
        r      = pend_q;
        cnt_d  = cnt_dec;
        expire = (pend_q != NONE) && (cnt_dec == '0);
      end

      // Acceptance is checked before expiry so a turn opening on its last frame is taken.
      if (r != NONE && dir_open(r)) begin
        cur_d  = r;
        pend_d = NONE;
        cnt_d  = '0;
      end else begin
        if (expire) begin
          pend_d = NONE;
        end else if (r != NONE) begin
          pend_d = r;
        end
        if (cur_q != NONE && !dir_open(cur_q)) begin
          cur_d = NONE;
        end
      end
    end

    key_d = dir_to_key(cur_d);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cur_q  <= NONE;
      pend_q <= NONE;
      cnt_q  <= '0;
      key_q  <= KEY_NONE;
    end else begin
      cur_q  <= cur_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      key_q  <= key_d;
    end
  end

  assign move_key   = key_q;
  assign cur_dir    = cur_q;
  assign pend_dir   = pend_q;
  assign pend_valid = (pend_q != NONE);

endmodule
